craft_round_controller: RTL and testbench



---
 rtl/craft_pkg.sv | 23 ++
 rtl/craft_round_controller_if.sv | 37 +++
 rtl/craft_phase_counter.sv | 40 ++++
 rtl/craft_round_controller.sv | 145 ++++++++++++++
 tb/tb_craft_round_controller.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/craft_pkg.sv
// craft_pkg: constants and types shared by the CRAFT round controller,
// key register and state datapath.
package craft_pkg;

  // Block parameters shared across the nibble-serial core
  localparam int CRAFT_ROUNDS    = 32;
  localparam int CRAFT_NIBBLES   = 16;
  localparam int CRAFT_MC_CYCLES = 4;

  // Round index width, matching the key register's r input
  localparam int CRAFT_RW = 8;

  // Controller sequencing states
  localparam int CRAFT_STATE_W = 3;
  typedef enum logic [CRAFT_STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MC   = 3'd2,
    ST_NIB  = 3'd3,
    ST_FIN  = 3'd4
  } craft_state_e;

endpackage

// File: rtl/craft_round_controller_if.sv
// craft_round_controller_if: start/ciphertext handshake plus the strobes the
// round controller drives into the key register and state datapath.
// Optional macro CRAFT_ROUND_CTRL_DECRYPT_EN adds the dec request bit.
interface craft_round_controller_if;
  import craft_pkg::*;

  logic                start;
  logic                out_ready;
`ifdef CRAFT_ROUND_CTRL_DECRYPT_EN
  logic                dec;
`endif
  logic                busy;
  logic                CK0;
  logic                mc_en;
  logic                en;
  logic [CRAFT_RW-1:0] r;
  logic [3:0]          nib;
  logic                last_round;
  logic                out_valid;

`ifdef CRAFT_ROUND_CTRL_DECRYPT_EN
  modport master (output start, output out_ready, output dec,
                  input busy, input CK0, input mc_en, input en, input r,
                  input nib, input last_round, input out_valid);
  modport slave  (input start, input out_ready, input dec,
                  output busy, output CK0, output mc_en, output en, output r,
                  output nib, output last_round, output out_valid);
`else
  modport master (output start, output out_ready,
                  input busy, input CK0, input mc_en, input en, input r,
                  input nib, input last_round, input out_valid);
  modport slave  (input start, input out_ready,
                  output busy, output CK0, output mc_en, output en, output r,
                  output nib, output last_round, output out_valid);
`endif

endinterface

// File: rtl/craft_phase_counter.sv
// craft_phase_counter: clearable modulo counter. It counts 0..last while
// enabled, wraps to 0, and flags the terminal value with tc.
module craft_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc    = en && (count_q == last);
  assign count = count_q;

  // Next count: clear wins, otherwise advance and wrap at the terminal value
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  // Count register with asynchronous clear on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/craft_round_controller.sv
// craft_round_controller: walks the CRAFT rounds for one block, driving the
// key register strobes (CK0, en, r) and the MixColumn/nibble phase strobes,
// and offers the finished block on a valid/ready handshake.
// Optional macro CRAFT_ROUND_CTRL_DECRYPT_EN adds a dec input that makes the
// round index count down from ROUNDS-1 to 0.
module craft_round_controller
  import craft_pkg::*;
#(
  parameter int ROUNDS    = CRAFT_ROUNDS,
  parameter int NIBBLES   = CRAFT_NIBBLES,
  parameter int MC_CYCLES = CRAFT_MC_CYCLES
) (
  input logic                     clk,
  input logic                     reset_n,
  craft_round_controller_if.slave bus
);

  localparam int PH_MAX = (NIBBLES > MC_CYCLES) ? NIBBLES : MC_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]     MC_LAST  = PH_W'(MC_CYCLES - 1);
  localparam logic [PH_W-1:0]     NIB_LAST = PH_W'(NIBBLES - 1);
  localparam logic [CRAFT_RW-1:0] R_LAST   = CRAFT_RW'(ROUNDS - 1);

  localparam logic [CRAFT_STATE_W-1:0] S_IDLE = ST_IDLE;
  localparam logic [CRAFT_STATE_W-1:0] S_LOAD = ST_LOAD;
  localparam logic [CRAFT_STATE_W-1:0] S_MC   = ST_MC;
  localparam logic [CRAFT_STATE_W-1:0] S_NIB  = ST_NIB;
  localparam logic [CRAFT_STATE_W-1:0] S_FIN  = ST_FIN;

  logic [CRAFT_STATE_W-1:0] state_q;
  logic [CRAFT_STATE_W-1:0] state_d;
  logic [CRAFT_RW-1:0]      r_q;
  logic [CRAFT_RW-1:0]      r_d;
  logic [PH_W-1:0]          phase_cnt;
  logic [PH_W-1:0]          phase_last;
  logic                     phase_tc;
  logic                     phase_en;
  logic                     dec_mode;
  logic                     last_round;

  assign phase_en   = (state_q == S_MC) || (state_q == S_NIB);
  assign phase_last = (state_q == S_NIB) ? NIB_LAST : MC_LAST;

  craft_phase_counter #(
    .WIDTH (PH_W)
  ) u_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .en      (phase_en),
    .last    (phase_last),
    .count   (phase_cnt),
    .tc      (phase_tc)
  );

`ifdef CRAFT_ROUND_CTRL_DECRYPT_EN
  logic dec_q;
  logic dec_d;

  // Capture the direction whenever a start request is accepted
  always_comb begin
    dec_d = dec_q;
    if (state_d == S_LOAD) begin
      dec_d = bus.dec;
    end
  end

  // Direction register for the current block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign dec_mode = dec_q;
`else
  assign dec_mode = 1'b0;
`endif

  assign last_round = dec_mode ? (r_q == '0) : (r_q == R_LAST);

  // Sequencing: LOAD once, then MC/NIB per round, then hold in FIN
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_MC;
        r_d     = dec_mode ? R_LAST : '0;
      end
      S_MC: begin
        if (phase_tc) begin
          state_d = S_NIB;
        end
      end
      S_NIB: begin
        if (phase_tc) begin
          if (last_round) begin
            state_d = S_FIN;
          end else begin
            state_d = S_MC;
            r_d     = dec_mode ? r_q - 1'b1 : r_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        if (bus.out_ready) begin
          state_d = bus.start ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and round index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.CK0        = (state_q == S_LOAD);
  assign bus.mc_en      = (state_q == S_MC);
  assign bus.en         = (state_q == S_NIB);
  assign bus.r          = r_q;
  assign bus.nib        = (state_q == S_NIB) ? 4'(phase_cnt) : 4'd0;
  assign bus.last_round = last_round;
  assign bus.out_valid  = (state_q == S_FIN);

endmodule

// File: tb/tb_craft_round_controller.sv
// tb_craft_round_controller: randomized bench for the CRAFT round controller.
// Expected outputs are computed from the cycle offset within a block.
module tb_craft_round_controller;
  import craft_pkg::*;

  localparam int R   = CRAFT_ROUNDS;
  localparam int NB  = CRAFT_NIBBLES;
  localparam int MCC = CRAFT_MC_CYCLES;
  localparam int RL  = MCC + NB;
  localparam int BLK = R * RL;

  logic clk = 1'b0;
  logic reset_n;

  int testsRun    = 0;
  int testsFailed = 0;
  int edgeCount   = 0;
  int lastR       = 0;
  bit lastDec     = 1'b0;
  bit drivenDec   = 1'b0;
  int validRise   = -1;
  int prevHold    = 0;

  craft_round_controller_if bus();

  craft_round_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used for latency measurements
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Counts one comparison and reports it if the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs and waits for the next sampling point
  task automatic applyStimulus(input bit s, input bit rdy, input bit d);
    bus.start     = s;
    bus.out_ready = rdy;
    drivenDec     = d;
`ifdef CRAFT_ROUND_CTRL_DECRYPT_EN
    bus.dec = d;
`endif
    @(negedge clk);
  endtask

  function automatic bit pickDec();
`ifdef CRAFT_ROUND_CTRL_DECRYPT_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Checks the quiet outputs shared by IDLE and FIN
  task automatic checkQuiet(input string tag, input bit fin);
    checkOutput({tag, ".busy"},   32'(bus.busy),      32'(fin));
    checkOutput({tag, ".valid"},  32'(bus.out_valid), 32'(fin));
    checkOutput({tag, ".CK0"},    32'(bus.CK0),       32'd0);
    checkOutput({tag, ".mc_en"},  32'(bus.mc_en),     32'd0);
    checkOutput({tag, ".en"},     32'(bus.en),        32'd0);
    checkOutput({tag, ".nib"},    32'(bus.nib),       32'd0);
    checkOutput({tag, ".r"},      32'(bus.r),         32'(lastR));
    checkOutput({tag, ".last"},   32'(bus.last_round),
                32'(lastDec ? (lastR == 0) : (lastR == R - 1)));
  endtask

  // Checks every output against its reset value
  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".busy"},  32'(bus.busy),       32'd0);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid),  32'd0);
    checkOutput({tag, ".CK0"},   32'(bus.CK0),        32'd0);
    checkOutput({tag, ".mc_en"}, 32'(bus.mc_en),      32'd0);
    checkOutput({tag, ".en"},    32'(bus.en),         32'd0);
    checkOutput({tag, ".nib"},   32'(bus.nib),        32'd0);
    checkOutput({tag, ".r"},     32'(bus.r),          32'd0);
    checkOutput({tag, ".last"},  32'(bus.last_round), 32'd0);
  endtask

  // Runs one block from IDLE or FIN, optionally aborting it with reset at
  // cycle offset abortAt, then holds FIN for holdCycles with out_ready low
  task automatic runBlock(input bit decMode, input int holdCycles, input int abortAt, input bit chained);
    int c0;
    bit s;
    bit rdy;
    c0 = edgeCount;
    applyStimulus(1'b1, 1'b1, decMode);
    for (int t = 1; t <= BLK + 1; t++) begin
      s   = bit'($urandom_range(0, 1));
      rdy = bit'($urandom_range(0, 1));
      if (t == 1) begin
        checkOutput("load.CK0",   32'(bus.CK0),       32'd1);
        checkOutput("load.busy",  32'(bus.busy),      32'd1);
        checkOutput("load.mc_en", 32'(bus.mc_en),     32'd0);
        checkOutput("load.en",    32'(bus.en),        32'd0);
        checkOutput("load.valid", 32'(bus.out_valid), 32'd0);
        checkOutput("load.r",     32'(bus.r),         32'(lastR));
      end else begin
        int idx;
        int k;
        int p;
        bit mc;
        idx = t - 2;
        k   = idx / RL;
        p   = idx % RL;
        mc  = (p < MCC);
        checkOutput("blk.busy",  32'(bus.busy),       32'd1);
        checkOutput("blk.CK0",   32'(bus.CK0),        32'd0);
        checkOutput("blk.mc_en", 32'(bus.mc_en),      32'(mc));
        checkOutput("blk.en",    32'(bus.en),         32'(!mc));
        checkOutput("blk.nib",   32'(bus.nib),        mc ? 32'd0 : 32'(p - MCC));
        checkOutput("blk.r",     32'(bus.r),          decMode ? 32'(R - 1 - k) : 32'(k));
        checkOutput("blk.last",  32'(bus.last_round), 32'(k == R - 1));
        checkOutput("blk.valid", 32'(bus.out_valid),  32'd0);
        if (k == 5 && p == MCC + 7) s = 1'b1;
        if (k == 3 && p == 1) rdy = 1'b1;
      end
      if (t == abortAt) begin
        reset_n = 1'b0;
        #1;
        checkResetValues("abort");
        lastR   = 0;
        lastDec = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkQuiet("postabort", 1'b0);
        validRise = -1;
        return;
      end
      applyStimulus(s, rdy, bit'($urandom_range(0, 1)));
    end
    lastR   = decMode ? 0 : R - 1;
    lastDec = decMode;
    checkOutput("latency", 32'(edgeCount - c0 - 1), 32'(1 + BLK));
    if (chained && validRise >= 0) begin
      checkOutput("b2b.interval", 32'(edgeCount - validRise), 32'(2 + BLK + prevHold));
    end
    validRise = edgeCount;
    prevHold  = holdCycles;
    for (int h = 0; h < holdCycles; h++) begin
      checkQuiet("finhold", 1'b1);
      applyStimulus(bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)));
    end
    checkQuiet("fin", 1'b1);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
`ifdef CRAFT_ROUND_CTRL_DECRYPT_EN
    bus.dec = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      checkQuiet("idle", 1'b0);
    end

    runBlock(pickDec(), 10, 0, 1'b0);
    runBlock(pickDec(), 0, 0, 1'b1);
    runBlock(pickDec(), 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkQuiet("toidle", 1'b0);

    runBlock(pickDec(), 0, 2 + 17 * RL + int'($urandom_range(0, RL - 1)), 1'b0);
    runBlock(pickDec(), 3, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkQuiet("toidle2", 1'b0);

    for (int b = 0; b < 2; b++) begin
      runBlock(pickDec(), int'($urandom_range(0, 5)), 0, 1'b0);
      runBlock(pickDec(), 0, 0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkQuiet("toidle3", 1'b0);
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 1'b1, drivenDec);
        checkQuiet("idlehold", 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
